// File: rtl/tt_lut_engine.sv
// Programmable N_CH-channel truth-table evaluator with an atomically committed shadow table
// and a one-stage valid/ready eval pipeline. Optional readback port: define TT_READBACK_EN.
module tt_lut_engine #(
   parameter int                 N_IN     = 4,
   parameter int                 N_CH     = 1,
   parameter int                 CFG_W    = 8,
   parameter logic [2**N_IN-1:0] RESET_TT = 16'h7176
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CFG_W-1:0]       cfg_data,
   input  logic                   cfg_last,
   output logic                   cfg_err,
   output logic                   tt_busy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_CH*N_IN-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef TT_READBACK_EN
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rb_sel,
   output logic [2**N_IN-1:0]     rb_tt,
`endif
   output logic [N_CH-1:0]        out_data
);

   localparam int TT_W   = 2**N_IN;
   localparam int FLAT_W = N_CH * TT_W;
   localparam int NB     = (FLAT_W + CFG_W - 1) / CFG_W;
   localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [FLAT_W-1:0] RESET_FLAT = {N_CH{RESET_TT}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

   state_t             r_state, w_state_next;
   logic [CNT_W-1:0]   r_count, w_count_next;
   logic               r_cfg_ready;
   logic               r_cfg_err, w_err_next;
   logic               w_cfg_acc, w_at_end;
   logic [FLAT_W-1:0]  r_shadow;
   logic [TT_W-1:0]    r_active [N_CH];
   logic [N_CH-1:0]    w_eval;
   logic [N_CH-1:0]    r_out_data;
   logic               r_out_valid;
   logic               w_in_ready, w_in_acc;

   assign w_cfg_acc = cfg_valid & r_cfg_ready;
   assign w_at_end  = (r_count == CNT_W'(NB - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_cfg_ready <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         r_cfg_ready <= (w_state_next != S_COMMIT);
         r_cfg_err   <= w_err_next;
      end
   end

   // A beat is well-formed only when cfg_last and "last word slot" coincide.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_err_next   = 1'b0;
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (w_cfg_acc) begin
               if (cfg_last && w_at_end) begin
                  w_state_next = S_COMMIT;
                  w_count_next = '0;
               end else if (cfg_last || w_at_end) begin
                  w_state_next = S_IDLE;
                  w_count_next = '0;
                  w_err_next   = 1'b1;
               end else begin
                  w_state_next = S_LOAD;
                  w_count_next = r_count + CNT_W'(1);
               end
            end
         end
         S_COMMIT: w_state_next = S_IDLE;
         default: begin
            w_state_next = S_IDLE;
            w_count_next = '0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_shadow
         // The final word may be partial; bits beyond the table are never stored.
         localparam int WB = ((FLAT_W - gi*CFG_W) < CFG_W) ? (FLAT_W - gi*CFG_W) : CFG_W;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_shadow[gi*CFG_W +: WB] <= RESET_FLAT[gi*CFG_W +: WB];
            else if (w_cfg_acc && (r_count == CNT_W'(gi)))
               r_shadow[gi*CFG_W +: WB] <= cfg_data[WB-1:0];
         end
      end

      for (gi = 0; gi < N_CH; gi++) begin : g_chan
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_active[gi] <= RESET_TT;
            else if (r_state == S_COMMIT)
               r_active[gi] <= r_shadow[gi*TT_W +: TT_W];
         end
         assign w_eval[gi] = r_active[gi][in_data[gi*N_IN +: N_IN]];
      end
   endgenerate

   assign w_in_ready = !r_out_valid | out_ready;
   assign w_in_acc   = in_valid & w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_in_acc) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_eval;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef TT_READBACK_EN
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   always_comb begin
      rb_tt = '0;
      for (int c = 0; c < N_CH; c++)
         if (rb_sel == SEL_W'(c)) rb_tt = r_active[c];
   end
`endif

   assign cfg_ready = r_cfg_ready;
   assign cfg_err   = r_cfg_err;
   assign tt_busy   = (r_state == S_LOAD);
   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_tt_lut_engine.sv
// Bench for tt_lut_engine: randomized load/eval traffic checked against a queue-based table model,
// plus a directed 2-channel instance.
module tb_tt_lut_engine;

   localparam int NB0 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       cfg_valid, cfg_ready, cfg_last, cfg_err, tt_busy;
   logic [7:0] cfg_data;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] in_data;
   logic [0:0] out_data;

   logic       c1_cfg_valid, c1_cfg_ready, c1_cfg_last, c1_cfg_err, c1_tt_busy;
   logic [7:0] c1_cfg_data;
   logic       c1_in_valid, c1_in_ready, c1_out_valid, c1_out_ready;
   logic [3:0] c1_in_data;
   logic [1:0] c1_out_data;
`ifdef TT_READBACK_EN
   logic [0:0]  rb0_sel, rb1_sel;
   logic [15:0] rb0_tt;
   logic [3:0]  rb1_tt;
`endif

   tt_lut_engine u_dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .cfg_last(cfg_last), .cfg_err(cfg_err), .tt_busy(tt_busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef TT_READBACK_EN
      .rb_sel(rb0_sel), .rb_tt(rb0_tt),
`endif
      .out_data(out_data)
   );

   tt_lut_engine #(.N_IN(2), .N_CH(2), .CFG_W(8), .RESET_TT(4'h9)) u_dut2 (
      .clk(clk), .rst(rst),
      .cfg_valid(c1_cfg_valid), .cfg_ready(c1_cfg_ready), .cfg_data(c1_cfg_data),
      .cfg_last(c1_cfg_last), .cfg_err(c1_cfg_err), .tt_busy(c1_tt_busy),
      .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_data(c1_in_data),
      .out_valid(c1_out_valid), .out_ready(c1_out_ready),
`ifdef TT_READBACK_EN
      .rb_sel(rb1_sel), .rb_tt(rb1_tt),
`endif
      .out_data(c1_out_data)
   );

   int n_vec, n_err;

   // Reference model: active table, pending committed table, received beats, output register.
   logic [15:0] m_tt, m_pend;
   logic        m_commit, m_ov, m_od, m_err, m_cfg_rdy;
   logic [7:0]  m_q[$];
   logic [3:0]  rt2 = 4'h9;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at a falling edge: drive, check current outputs, advance the model over the next rising edge.
   task automatic cycle(input logic cv, input logic [7:0] cd, input logic cl,
                        input logic iv, input logic [3:0] idx, input logic ordy);
      logic acc_in, acc_cfg;
      cfg_valid = cv; cfg_data = cd; cfg_last = cl;
      in_valid = iv; in_data = idx; out_ready = ordy;
      #1;
      check_val("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) check_val("out_data", 32'(out_data), 32'(m_od));
      check_val("in_ready", 32'(in_ready), 32'(!m_ov || ordy));
      check_val("cfg_ready", 32'(cfg_ready), 32'(m_cfg_rdy));
      check_val("tt_busy", 32'(tt_busy), 32'(m_q.size() != 0));
      check_val("cfg_err", 32'(cfg_err), 32'(m_err));
      acc_in  = iv && (!m_ov || ordy);
      acc_cfg = cv && m_cfg_rdy;
      if (acc_in) begin
         m_od = m_tt[idx];
         m_ov = 1'b1;
         $display("op  idx=%0d table=%04h expect=%0b", idx, m_tt, m_od);
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      if (m_commit) begin
         m_tt = m_pend;
         m_commit = 1'b0;
      end
      m_err = 1'b0;
      if (acc_cfg) begin
         $display("cfg data=%02h last=%0b beat=%0d", cd, cl, m_q.size() + 1);
         m_q.push_back(cd);
         if (cl || m_q.size() == NB0) begin
            if (cl && m_q.size() == NB0) begin
               m_pend = {m_q[1], m_q[0]};
               m_commit = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            m_q.delete();
         end
      end
      m_cfg_rdy = !m_commit;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'(1'b0));
      check_val("rst_out_data", 32'(out_data), 32'(1'b0));
      check_val("rst_in_ready", 32'(in_ready), 32'(1'b1));
      check_val("rst_cfg_ready", 32'(cfg_ready), 32'(1'b0));
      check_val("rst_tt_busy", 32'(tt_busy), 32'(1'b0));
      check_val("rst_cfg_err", 32'(cfg_err), 32'(1'b0));
      m_tt = 16'h7176; m_q.delete(); m_commit = 1'b0;
      m_ov = 1'b0; m_od = 1'b0; m_err = 1'b0; m_cfg_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] v;
      logic       cl;
      n_vec = 0; n_err = 0; rst = 1'b0;
      cfg_valid = 0; cfg_data = 0; cfg_last = 0; in_valid = 0; in_data = 0; out_ready = 1;
      c1_cfg_valid = 0; c1_cfg_data = 0; c1_cfg_last = 0;
      c1_in_valid = 0; c1_in_data = 0; c1_out_ready = 1;
`ifdef TT_READBACK_EN
      rb0_sel = 0; rb1_sel = 0;
`endif
      @(negedge clk);
      do_reset();

      // Two-channel instance: reset table, then OR/XOR tables in a single beat.
      check_val("u2_cfg_ready_rst", 32'(c1_cfg_ready), 32'(1'b0));
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         c1_in_valid = 1'b1; c1_in_data = v;
         @(negedge clk);
         check_val("u2_reset_tt", 32'(c1_out_data), 32'({rt2[v[3:2]], rt2[v[1:0]]}));
      end
      c1_in_valid = 1'b0;
      c1_cfg_valid = 1'b1; c1_cfg_data = 8'h6E; c1_cfg_last = 1'b1;
      #1 check_val("u2_cfg_ready", 32'(c1_cfg_ready), 32'(1'b1));
      @(negedge clk);
      c1_cfg_valid = 1'b0; c1_cfg_last = 1'b0;
      #1;
      check_val("u2_commit_ready", 32'(c1_cfg_ready), 32'(1'b0));
      check_val("u2_commit_busy", 32'(c1_tt_busy), 32'(1'b0));
      check_val("u2_commit_err", 32'(c1_cfg_err), 32'(1'b0));
      @(negedge clk);
`ifdef TT_READBACK_EN
      rb1_sel = 1'b0; #1 check_val("rb_u2_ch0", 32'(rb1_tt), 32'(4'hE));
      rb1_sel = 1'b1; #1 check_val("rb_u2_ch1", 32'(rb1_tt), 32'(4'h6));
      rb0_sel = 1'b1; #1 check_val("rb_u1_oob", 32'(rb0_tt), 32'(16'h0));
      rb0_sel = 1'b0; #1 check_val("rb_u1_ch0", 32'(rb0_tt), 32'(16'h7176));
`endif
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         c1_in_valid = 1'b1; c1_in_data = v;
         @(negedge clk);
         check_val("u2_or_xor", 32'(c1_out_data), 32'({v[3] ^ v[2], v[1] | v[0]}));
      end
      c1_in_valid = 1'b0;

      // Single-channel instance: directed scenarios.
      do_reset();
      cycle(0, 8'h00, 0, 1, 4'd0, 1);
      cycle(0, 8'h00, 0, 1, 4'd1, 1);
      cycle(0, 8'h00, 0, 1, 4'd3, 1);
      cycle(0, 8'h00, 0, 1, 4'd8, 1);
      cycle(0, 8'h00, 0, 1, 4'd9, 1);
      cycle(0, 8'h00, 0, 1, 4'd15, 1);
      check_val("tp_idx15", 32'(out_data), 32'(1'b0));
      cycle(0, 8'h00, 0, 0, 4'd0, 1);
      cycle(1, 8'hFF, 0, 0, 4'd0, 1);
      cycle(1, 8'h00, 1, 0, 4'd0, 1);
      cycle(0, 8'h00, 0, 1, 4'd8, 1);
      check_val("tp_commit_old", 32'(out_data), 32'(1'b1));
      cycle(0, 8'h00, 0, 1, 4'd7, 1);
      cycle(0, 8'h00, 0, 1, 4'd8, 1);
      check_val("tp_new_idx8", 32'(out_data), 32'(1'b0));
      cycle(1, 8'hAA, 1, 0, 4'd0, 1);
      cycle(0, 8'h00, 0, 1, 4'd1, 1);
      cycle(0, 8'h00, 0, 1, 4'd1, 1);
      for (int k = 0; k < 3; k++) cycle(0, 8'h00, 0, 1, 4'd2, 0);
      cycle(0, 8'h00, 0, 1, 4'd2, 1);
      cycle(0, 8'h00, 0, 0, 4'd0, 1);
      cycle(1, 8'h12, 0, 0, 4'd0, 1);
      do_reset();
      cycle(0, 8'h00, 0, 1, 4'd4, 1);
      cycle(0, 8'h00, 0, 0, 4'd0, 1);
      check_val("tp_rst_idx4", 32'(out_data), 32'(1'b1));

      // Randomized traffic with occasional malformed loads and asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         if (m_q.size() == NB0 - 1) cl = ($urandom_range(0, 9) != 0);
         else                       cl = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 399) == 0)
            do_reset();
         else
            cycle(1'($urandom_range(0, 1)), 8'($urandom), cl,
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 7));
      end
      cycle(0, 8'h00, 0, 0, 4'd0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tt_lut_engine.md
Name: tt_lut_engine

Overview:
Parametrised, pipelined truth-table evaluator. It generalises fixed 4-input/1-output synthesized gate netlists into a run-time programmable N_IN-input LUT with N_CH independent channels. Tables are loaded through a word-serial config port into a shadow buffer and committed atomically. Evaluation uses a valid/ready stream with one registered output stage. It sits between the stimulus sequencer and the result collector of the circuit-evaluation datapath.

Parameters:
N_IN, 4, inputs per channel; each table is TT_W = 2**N_IN bits, legal range 1..8.
N_CH, 1, number of independent channels, each with its own table.
CFG_W, 8, config word width; beats per load: NB = ceil(N_CH*TT_W / CFG_W).
RESET_TT, 16'h7176, per-channel table loaded at reset, replicated to all channels; width TT_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  config beat valid
cfg_ready  output  1  config beat accepted when valid&ready
cfg_data  input  CFG_W  table bits, LSB-first; beat k carries flat bits [k*CFG_W +: CFG_W]
cfg_last  input  1  marks final beat of a load
cfg_err  output  1  one-cycle pulse on malformed load
tt_busy  output  1  high while a load is in progress (LOAD state)
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when valid&ready
in_data  input  N_CH*N_IN  channel c index = in_data[c*N_IN +: N_IN]
out_valid  output  1  result valid
out_ready  input  1  downstream ready
out_data  output  N_CH  out_data[c] = active_tt[c][index_c]

Behaviour:
- Flat table layout: channel c occupies flat bits [c*TT_W +: TT_W]. Bits beyond N_CH*TT_W in the last beat are ignored.
- Reset values: active and shadow tables = RESET_TT per channel; FSM = IDLE; beat counter = 0; cfg_ready=0; cfg_err=0; tt_busy=0; out_valid=0; out_data=0; in_ready=1.
- Config FSM:
  - IDLE: cfg_ready=1. An accepted beat writes shadow word 0 and moves to LOAD with count=1. If that beat has cfg_last and NB==1, go to COMMIT instead.
  - LOAD: cfg_ready=1; tt_busy=1. Each accepted beat writes shadow word[count] and increments count.
    - cfg_last on beat number NB (count==NB-1 at accept) goes to COMMIT.
    - cfg_last early, or beat NB accepted without cfg_last, pulses cfg_err for one cycle, discards the shadow buffer (active table untouched) and returns to IDLE.
  - COMMIT: one cycle, cfg_ready=0; active <= shadow; then IDLE.
- Eval pipeline:
  - in_ready = !out_valid | out_ready.
  - On in_valid&in_ready, out_data is registered from the current active table and out_valid=1. Latency is 1 cycle.
  - out_valid clears on out_ready with no new accept.
  - out_data is held stable while out_valid & !out_ready.
- Table swap coherence: an operand accepted in the COMMIT cycle uses the old table. Operands accepted from the next cycle onward use the new table. No bubble is inserted; eval is never stalled by config.
- Simultaneous load and eval are fully independent.
- Asynchronous reset mid-load drops the shadow contents and restores RESET_TT to both tables. Reset mid-stall drops the pending result.

Optional Feature:
Macro TT_READBACK_EN.
- Defined: adds input rb_sel (width max(1,clog2(N_CH))) and output rb_tt (TT_W), combinationally = active table of channel rb_sel. Out-of-range rb_sel returns 0.
- Undefined: these ports do not exist; no readback logic is built.

Test Plan:
- Reset defaults, N_IN=4, N_CH=1: index sequence 0,1,3,8,9,15 -> out_data 0,1,0,1,0,0 (table 0x7176), each 1 cycle after accept.
- Load 0x00FF as beats 0xFF, 0x00 (last on beat 2) -> after the COMMIT cycle, index 7 -> 1 and index 8 -> 0. An operand accepted in the COMMIT cycle with index 8 -> 1 (old table).
- Malformed load: cfg_last on beat 1 of 2 -> cfg_err pulses one cycle; index 1 still -> 1 (0x7176 retained).
- Backpressure: out_ready=0 for 3 cycles after result index 1 -> out_valid=1, out_data=1 held, in_ready=0; release -> next operand accepted the same cycle.
- N_CH=2, N_IN=2, CFG_W=8: one beat 0x6E (ch0 table 0xE = OR, ch1 table 0x6 = XOR) -> in_data 4'b11_01 -> out_data 2'b01. With TT_READBACK_EN, rb_sel=1 -> rb_tt=4'h6.
- Assert rst during LOAD beat 1 of 2 -> tt_busy=0, cfg_err=0, index 4 -> 1 (RESET_TT).
